cursor_ctrl: RTL and testbench
==============================

CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 The block SHALL have parameter H_MAX, default 319, meaning the maximum legal cursor x in 320x240 frame coordinates.
REQ-002 The block SHALL have parameter V_MAX, default 239, meaning the maximum legal cursor y.
REQ-003 The block SHALL have parameter SMOOTH_SHIFT, default 2, meaning the smoothing divisor exponent (0 = no smoothing).
REQ-004 clk_in  input  1  the single system clock; all state changes on its rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-006 pos_valid_in  input  1  a position sample is offered.
REQ-007 pos_ready_out  output  1  the block accepts a sample this cycle.
REQ-008 pos_x_in  input  10  raw sample x.
REQ-009 pos_y_in  input  9  raw sample y.
REQ-010 frame_start_in  input  1  single-cycle pulse marking the start of vertical blank.
REQ-011 width_up_in / width_down_in  input  1 each  single-cycle stroke-width step requests.
REQ-012 type_toggle_in  input  1  single-cycle cursor-shape toggle request.
REQ-013 x_out  output  10; y_out  output  9  committed cursor position for the overlay renderer.
REQ-014 stroke_width_out  output  3; cursor_type_out  output  1  committed brush width and shape (1 = crosshair, 0 = square).
REQ-015 update_out  output  1  single-cycle pulse when any committed output changed.

Function
REQ-016 The block SHALL use FSM states IDLE, PENDING, FILTER, COMMIT.
REQ-017 Handshake: a sample transfers when pos_valid_in and pos_ready_out are both 1 on a rising edge; pos_ready_out SHALL be 1 only in IDLE.
REQ-018 On transfer, the sample SHALL be clamped (x > H_MAX -> H_MAX, y > V_MAX -> V_MAX), stored in a one-entry pending buffer, and the FSM SHALL go IDLE -> PENDING.
REQ-019 In IDLE or PENDING, frame_start_in SHALL move the FSM to FILTER; this takes priority over a same-cycle transfer in IDLE, and that sample is not accepted.
REQ-020 FILTER (one cycle), with a pending sample: per axis compute signed d = target - current; step = d >>> SMOOTH_SHIFT (arithmetic shift); if d != 0 and step == 0, step = sign(d); next = current + step.
REQ-021 FILTER without a pending sample: next position = current position.
REQ-022 Position arithmetic SHALL be at least 11-bit signed; the result SHALL always lie in [0, H_MAX] x [0, V_MAX].
REQ-023 COMMIT (one cycle) SHALL load the next position, the shadow width, and the shadow type into the outputs, clear the pending buffer, and return to IDLE.
REQ-024 Outputs SHALL change only on the COMMIT edge, giving frame-coherent updates; latency is frame_start_in at cycle N, outputs valid from N+2.
REQ-025 update_out SHALL be 1 on the cycle after COMMIT only if any output value differs from its previous value.
REQ-026 Shadow width: +1 per width_up_in, saturating at 7; -1 per width_down_in, saturating at 0; both in the same cycle -> no change. It is updated in any state.
REQ-027 Shadow type: inverted per type_toggle_in pulse in any state.
REQ-028 frame_start_in during FILTER or COMMIT SHALL be ignored.
REQ-029 pos_valid_in SHALL be ignored outside IDLE; an upstream producer holds the sample until it is accepted.

Reset
REQ-030 While rst_n_in = 0, and immediately on assertion, the block SHALL set: FSM = IDLE, pending empty, x_out = 160, y_out = 120, stroke_width_out = 1, cursor_type_out = 0, update_out = 0, pos_ready_out = 0; shadow width = 1, shadow type = 0.
REQ-031 pos_ready_out SHALL rise on the first clock edge after rst_n_in deasserts; reset mid-FILTER or mid-COMMIT SHALL discard the pending sample.

Verification
REQ-032 Reset, then offer sample (200,120), then frame_start -> ready drops after transfer; x_out = 170 at N+2; update_out pulses once.
REQ-033 SMOOTH_SHIFT = 2, current x = 160, target 162, repeated frames -> x goes 161, 162, then holds; no update_out once converged.
REQ-034 Sample (1000,500) -> clamped to (319,239); after enough frames, x_out = 319 and y_out = 239 exactly, never beyond.
REQ-035 Eight width_up pulses, then frame_start -> stroke_width_out = 7; width_up and width_down in the same cycle -> unchanged; nine width_down pulses -> 0.
REQ-036 frame_start coincident with valid in IDLE -> sample not accepted; frame_start during COMMIT ignored; type_toggle in FILTER is applied at that COMMIT.
REQ-037 rst_n_in pulsed low asynchronously mid-FILTER -> outputs return to reset values without a clock edge; pos_ready_out = 1 after the first edge following release.

Source files
------------

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: frame-coherent smoothed cursor position, brush width and shape for the overlay renderer
module cursor_ctrl #(
  parameter int H_MAX        = 319,
  parameter int V_MAX        = 239,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       pos_valid_in,
  output logic       pos_ready_out,
  input  logic [9:0] pos_x_in,
  input  logic [8:0] pos_y_in,
  input  logic       frame_start_in,
  input  logic       width_up_in,
  input  logic       width_down_in,
  input  logic       type_toggle_in,
  output logic [9:0] x_out,
  output logic [8:0] y_out,
  output logic [2:0] stroke_width_out,
  output logic       cursor_type_out,
  output logic       update_out
);
  typedef enum logic [1:0] {IDLE, PENDING, FILTER, COMMIT} state_t;
  state_t state;
  logic pend, st, st_n, xfer, changed;
  logic [9:0] tx, cx, nx;
  logic [8:0] ty, cy, ny;
  logic [2:0] sw, sw_n;
  // one smoothing step; the result always lies between current and target
  function automatic logic signed [10:0] step_to(input logic signed [10:0] cur, input logic signed [10:0] tgt);
    logic signed [10:0] d, s;
    d = tgt - cur;
    s = d >>> SMOOTH_SHIFT;
    return cur + ((d != 11'sd0 && s == 11'sd0) ? 11'sd1 : s);
  endfunction
  always_comb begin
    xfer = pos_valid_in && pos_ready_out;
    cx = (pos_x_in > 10'(H_MAX)) ? 10'(H_MAX) : pos_x_in;
    cy = (pos_y_in > 9'(V_MAX)) ? 9'(V_MAX) : pos_y_in;
    nx = pend ? 10'(step_to({1'b0, x_out}, {1'b0, tx})) : x_out;
    ny = pend ? 9'(step_to({2'b0, y_out}, {2'b0, ty})) : y_out;
    sw_n = (width_up_in && !width_down_in && sw != 3'd7) ? sw + 3'd1 :
           (width_down_in && !width_up_in && sw != 3'd0) ? sw - 3'd1 : sw;
    st_n = st ^ type_toggle_in;
    changed = {nx, ny, sw_n, st_n} != {x_out, y_out, stroke_width_out, cursor_type_out};
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      pend <= 1'b0;
      tx <= '0;
      ty <= '0;
      sw <= 3'd1;
      st <= 1'b0;
      x_out <= 10'd160;
      y_out <= 9'd120;
      stroke_width_out <= 3'd1;
      cursor_type_out <= 1'b0;
      update_out <= 1'b0;
      pos_ready_out <= 1'b0;
    end else begin
      sw <= sw_n;
      st <= st_n;
      update_out <= 1'b0;
      case (state)
        IDLE: begin
          pos_ready_out <= !(frame_start_in || xfer);
          if (frame_start_in) state <= FILTER;
          else if (xfer) begin
            tx <= cx;
            ty <= cy;
            pend <= 1'b1;
            state <= PENDING;
          end
        end
        PENDING: if (frame_start_in) state <= FILTER;
        FILTER: begin
          x_out <= nx;
          y_out <= ny;
          stroke_width_out <= sw_n;
          cursor_type_out <= st_n;
          update_out <= changed;
          state <= COMMIT;
        end
        COMMIT: begin
          pend <= 1'b0;
          pos_ready_out <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed stimulus with a frame-level reference model checked every cycle
module tb_cursor_ctrl;
  localparam int SS = 2;
  logic clk_in = 0, rst_n_in = 0;
  logic pos_valid_in = 0, frame_start_in = 0, width_up_in = 0, width_down_in = 0, type_toggle_in = 0;
  logic [9:0] pos_x_in = 0;
  logic [8:0] pos_y_in = 0;
  logic pos_ready_out, cursor_type_out, update_out;
  logic [9:0] x_out;
  logic [8:0] y_out;
  logic [2:0] stroke_width_out;
  int checks = 0, errors = 0;
  cursor_ctrl #(.H_MAX(319), .V_MAX(239), .SMOOTH_SHIFT(SS)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .pos_valid_in(pos_valid_in), .pos_ready_out(pos_ready_out),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .frame_start_in(frame_start_in),
    .width_up_in(width_up_in), .width_down_in(width_down_in), .type_toggle_in(type_toggle_in),
    .x_out(x_out), .y_out(y_out), .stroke_width_out(stroke_width_out),
    .cursor_type_out(cursor_type_out), .update_out(update_out));
  always #5 clk_in = ~clk_in;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: m_phase counts cycles since a frame was taken (0 = not in a frame)
  int m_phase, m_x, m_y, m_w, m_t, m_sw, m_st, m_tx, m_ty;
  bit m_pend, m_ready, m_upd;
  function automatic int glide(int cur, int tgt);
    int d, s;
    d = tgt - cur;
    s = d >>> SS;
    if (d != 0 && s == 0) s = (d > 0) ? 1 : -1;
    return cur + s;
  endfunction
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_phase = 0; m_pend = 0; m_ready = 0; m_upd = 0;
      m_x = 160; m_y = 120; m_w = 1; m_t = 0; m_sw = 1; m_st = 0;
    end else begin
      int nsw, nst, nx, ny;
      nsw = m_sw;
      if (width_up_in && !width_down_in) nsw = (m_sw < 7) ? m_sw + 1 : 7;
      if (width_down_in && !width_up_in) nsw = (m_sw > 0) ? m_sw - 1 : 0;
      nst = m_st ^ int'(type_toggle_in);
      m_upd = 0;
      if (m_phase == 1) begin
        nx = m_pend ? glide(m_x, m_tx) : m_x;
        ny = m_pend ? glide(m_y, m_ty) : m_y;
        m_upd = (nx != m_x) || (ny != m_y) || (nsw != m_w) || (nst != m_t);
        m_x = nx; m_y = ny; m_w = nsw; m_t = nst;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_pend = 0; m_phase = 0; m_ready = 1;
      end else if (frame_start_in) begin
        m_phase = 1; m_ready = 0;
      end else if (pos_valid_in && m_ready) begin
        m_pend = 1; m_ready = 0;
        m_tx = (int'(pos_x_in) > 319) ? 319 : int'(pos_x_in);
        m_ty = (int'(pos_y_in) > 239) ? 239 : int'(pos_y_in);
      end else m_ready = !m_pend;
      m_sw = nsw; m_st = nst;
    end
  end
  always @(negedge clk_in) begin
    chk("x", int'(x_out), m_x);
    chk("y", int'(y_out), m_y);
    chk("width", int'(stroke_width_out), m_w);
    chk("type", int'(cursor_type_out), m_t);
    chk("update", int'(update_out), int'(m_upd));
    chk("ready", int'(pos_ready_out), int'(m_ready));
  end
  task automatic send(input int x, input int y);
    bit done = 0;
    @(posedge clk_in); #2;
    pos_valid_in = 1; pos_x_in = 10'(x); pos_y_in = 9'(y);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_in);
      if (pos_ready_out) done = 1;
      @(posedge clk_in); #2;
    end
    pos_valid_in = 0;
    chk("handshake_timeout", int'(done), 1);
  endtask
  task automatic frame();
    @(posedge clk_in); #2 frame_start_in = 1;
    @(posedge clk_in); #2 frame_start_in = 0;
  endtask
  task automatic commit_frame();
    frame();
    @(negedge clk_in);
    @(negedge clk_in);
  endtask
  task automatic glide_frame(input int x, input int y);
    send(x, y);
    commit_frame();
  endtask
  task automatic pulse(input bit up, input bit dn);
    @(posedge clk_in); #2 width_up_in = up; width_down_in = dn;
    @(posedge clk_in); #2 width_up_in = 0; width_down_in = 0;
  endtask
  task automatic reset_pulse();
    @(posedge clk_in); #2 rst_n_in = 0;
    repeat (2) @(posedge clk_in);
    #2 rst_n_in = 1;
  endtask
  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_x", int'(x_out), 160);
    chk("rst_y", int'(y_out), 120);
    chk("rst_width", int'(stroke_width_out), 1);
    chk("rst_type", int'(cursor_type_out), 0);
    chk("rst_update", int'(update_out), 0);
    chk("rst_ready", int'(pos_ready_out), 0);
    #1 rst_n_in = 1;
    @(posedge clk_in); @(negedge clk_in);
    chk("ready_after_release", int'(pos_ready_out), 1);
    send(200, 120);
    @(negedge clk_in);
    chk("ready_drop", int'(pos_ready_out), 0);
    frame();
    @(negedge clk_in);
    chk("x_hold_n1", int'(x_out), 160);
    @(negedge clk_in);
    chk("x_n2", int'(x_out), 170);
    chk("upd_n2", int'(update_out), 1);
    @(negedge clk_in);
    chk("upd_single", int'(update_out), 0);
    reset_pulse();
    glide_frame(162, 120);
    chk("conv_1", int'(x_out), 161);
    glide_frame(162, 120);
    chk("conv_2", int'(x_out), 162);
    glide_frame(162, 120);
    chk("conv_hold", int'(x_out), 162);
    chk("conv_no_upd", int'(update_out), 0);
    send(300, 200);
    frame();
    #1 rst_n_in = 0;
    #1;
    chk("async_x", int'(x_out), 160);
    chk("async_width", int'(stroke_width_out), 1);
    chk("async_ready", int'(pos_ready_out), 0);
    @(posedge clk_in); #2 rst_n_in = 1;
    @(negedge clk_in);
    chk("ready_before_edge", int'(pos_ready_out), 0);
    @(posedge clk_in); @(negedge clk_in);
    chk("ready_first_edge", int'(pos_ready_out), 1);
    for (int i = 0; i < 25; i++) glide_frame(1000, 500);
    chk("clamp_x", int'(x_out), 319);
    chk("clamp_y", int'(y_out), 239);
    for (int i = 0; i < 8; i++) pulse(1, 0);
    commit_frame();
    chk("width_sat_hi", int'(stroke_width_out), 7);
    pulse(1, 1);
    commit_frame();
    chk("width_both", int'(stroke_width_out), 7);
    chk("width_both_upd", int'(update_out), 0);
    for (int i = 0; i < 9; i++) pulse(0, 1);
    commit_frame();
    chk("width_sat_lo", int'(stroke_width_out), 0);
    @(posedge clk_in); #2;
    pos_valid_in = 1; pos_x_in = 10; pos_y_in = 10; frame_start_in = 1;
    @(posedge clk_in); #2;
    pos_valid_in = 0; frame_start_in = 0; type_toggle_in = 1;
    @(posedge clk_in); #2;
    type_toggle_in = 0; frame_start_in = 1;
    @(negedge clk_in);
    chk("toggle_in_filter", int'(cursor_type_out), 1);
    chk("coincident_not_taken", int'(x_out), 319);
    chk("toggle_upd", int'(update_out), 1);
    @(posedge clk_in); #2 frame_start_in = 0;
    repeat (3) @(negedge clk_in);
    chk("commit_frame_ignored", int'(update_out), 0);
    chk("idle_after", int'(pos_ready_out), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
